axi_read_master: RTL and testbench

AXI4 read-channel initiator that issues one INCR read burst per accepted command and streams the returned beats to a local consumer over a valid/ready interface. It drives the AR and R channels of an AXI slave such as the team's slave RAM. It checks response codes and rlast framing, then reports completion and error status per burst. Only one burst is outstanding at a time; there is no write channel.

---
 rtl/axi_read_master_if.sv | 58 +++++
 rtl/axi_read_master.sv | 112 +++++++++++
 tb/tb_axi_read_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_master_if.sv
// Bundles the command, AXI read (AR/R), beat-output and status signals of the read master.
// The master modport is the initiator's view; the slave modport is the view of whatever surrounds it.
interface axi_read_master_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [7:0]               cmd_len;
  logic [2:0]               cmd_size;

  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;

  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;

  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size,
    output cmd_ready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output out_data, out_last, out_valid,
    input  out_ready,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_size,
    input  cmd_ready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  out_data, out_last, out_valid,
    output out_ready,
    input  busy, done, err
  );
endinterface

// File: rtl/axi_read_master.sv
// Single-outstanding AXI4 INCR read initiator; R beats pass straight through to a valid/ready consumer.
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ADDR   | AR request presented, held until arready
// DATA   | R beats forwarded to the consumer, framing/response checked
// DONE   | one-cycle completion pulse, err valid
module axi_read_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input logic              aclk,
  input logic              aresetn,
  axi_read_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned SIZE_LOG2 = $clog2(STROBE_WIDTH);

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               len_q, len_d;
  logic [2:0]               size_q, size_d;
  logic [8:0]               beat_cnt_q, beat_cnt_d;
  logic                     err_q, err_d;

  logic in_data;
  logic last_beat;

  assign in_data   = (state_q == S_DATA);
  assign last_beat = (beat_cnt_q == {1'b0, len_q});

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d     = bus.cmd_addr;
          len_d      = bus.cmd_len;
          size_d     = bus.cmd_size;
          beat_cnt_d = 9'd0;
          err_d      = 1'b0;
          // A beat wider than the data bus can never be served: fail without touching AR.
          if (32'(bus.cmd_size) > SIZE_LOG2) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.arready) state_d = S_ADDR + 2'd1;
      end
      S_DATA: begin
        if (bus.rvalid && bus.out_ready) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (bus.rresp != 2'b00) err_d = 1'b1;
          // Early or missing rlast both flag the burst; the beat count alone ends it.
          if (bus.rlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;

  assign bus.arvalid   = (state_q == S_ADDR);
  assign bus.araddr    = addr_q;
  assign bus.arlen     = len_q;
  assign bus.arsize    = size_q;
  assign bus.arburst   = 2'b01;

  assign bus.rready    = in_data & bus.out_ready;
  assign bus.out_valid = in_data & bus.rvalid;
  assign bus.out_data  = bus.rdata;
  assign bus.out_last  = in_data & last_beat;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: a table of bursts driven against a small R-channel slave model,
// plus hand-written sequences for reset state and a reset in the middle of a burst.
module tb_axi_read_master;

  logic aclk;
  logic aresetn;

  axi_read_master_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8)) bus ();

  axi_read_master #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.master)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          ar_delay;
    bit          toggle;
    logic [31:0] base;
    int          resp_beat;
    int          early_beat;
    bit          drop_last;
    int          exp_ar;
    int          exp_beats;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  beats, idx, ar_hs, done_cyc, cyc;
    bit  slave_on, ar_bad, rr_bad, data_bad, last_bad, err_seen, got, got_done;
    beats = 0; idx = 0; ar_hs = 0; done_cyc = 0;
    slave_on = 0; ar_bad = 0; rr_bad = 0; data_bad = 0; last_bad = 0;
    err_seen = 0; got = 0; got_done = 0;

    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge aclk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = v.addr;
      bus.cmd_len   = v.len;
      bus.cmd_size  = v.size;
      bus.arready   = 1'b0;
      bus.rvalid    = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      got = bus.cmd_ready;
    end
    check({tag, "_accept"}, 32'(got), 32'd1);
    if (!got) begin
      bus.cmd_valid = 1'b0;
      return;
    end

    for (cyc = 1; cyc < 300 && !got_done; cyc++) begin
      @(posedge aclk); #1;
      bus.cmd_valid = 1'b0;
      bus.arready   = (cyc > v.ar_delay);
      bus.out_ready = v.toggle ? cyc[0] : 1'b1;
      bus.rvalid    = slave_on && (idx <= int'(v.len));
      bus.rdata     = v.base + 32'(idx);
      bus.rresp     = (idx == v.resp_beat) ? 2'b10 : 2'b00;
      bus.rlast     = ((idx == int'(v.len)) && !v.drop_last) || (idx == v.early_beat);
      #1;
      if (bus.arvalid) begin
        if (bus.araddr !== v.addr || bus.arlen !== v.len || bus.arsize !== v.size ||
            bus.arburst !== 2'b01) ar_bad = 1;
        if (bus.arready) begin
          ar_hs++;
          slave_on = 1;
        end
      end
      if (bus.rvalid && (bus.rready !== bus.out_ready)) rr_bad = 1;
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_data !== v.base + 32'(beats)) data_bad = 1;
        if (bus.out_last !== (beats == int'(v.len))) last_bad = 1;
        beats++;
      end
      if (bus.rvalid && bus.rready) idx++;
      if (bus.done) begin
        got_done = 1;
        err_seen = bus.err;
        done_cyc = cyc;
      end
    end

    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_ar_handshakes"}, 32'(ar_hs), 32'(v.exp_ar));
    check({tag, "_ar_stable"}, 32'(ar_bad), 32'd0);
    check({tag, "_rready_mirror"}, 32'(rr_bad), 32'd0);
    check({tag, "_beat_data"}, 32'(data_bad), 32'd0);
    check({tag, "_out_last"}, 32'(last_bad), 32'd0);
    check({tag, "_beat_count"}, 32'(beats), 32'(v.exp_beats));
    check({tag, "_err"}, 32'(err_seen), 32'(v.exp_err));
    if (v.exp_cyc != 0) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_cyc));

    @(posedge aclk); #1;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    #1;
    check({tag, "_single_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err_held"}, 32'(bus.err), 32'(v.exp_err));
    check({tag, "_idle_again"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    bit saw_done;
    //          addr   len   size dly tog base          resp early drop ar beats err cyc
    vecs[0] = '{8'h10, 8'd0, 3'd2, 0, 0, 32'hDEADBEEF, -1,  -1,  0,   1, 1,    0,  3};
    vecs[1] = '{8'h20, 8'd3, 3'd2, 0, 1, 32'h0000_1000, -1, -1,  0,   1, 4,    0,  0};
    vecs[2] = '{8'h33, 8'd1, 3'd1, 5, 0, 32'h0000_2000, -1, -1,  0,   1, 2,    0,  9};
    vecs[3] = '{8'h40, 8'd3, 3'd2, 0, 0, 32'h0000_3000, 1,  -1,  0,   1, 4,    1,  6};
    vecs[4] = '{8'h50, 8'd3, 3'd2, 0, 0, 32'h0000_4000, -1, 0,   0,   1, 4,    1,  6};
    vecs[5] = '{8'h60, 8'd3, 3'd2, 0, 0, 32'h0000_5000, -1, -1,  1,   1, 4,    1,  6};
    vecs[6] = '{8'h70, 8'd0, 3'd3, 0, 0, 32'h0000_6000, -1, -1,  0,   0, 0,    1,  1};
    vecs[7] = '{8'h81, 8'd0, 3'd0, 0, 0, 32'h0000_7000, -1, -1,  0,   1, 1,    0,  3};

    aresetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_size  = '0;
    bus.arready   = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = '0;
    bus.rlast     = 1'b0;
    bus.rvalid    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #2;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_quiet", {26'd0, bus.arvalid, bus.rready, bus.out_valid, bus.out_last,
                        bus.done, bus.busy}, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an 8-beat burst; rvalid is already high during ADDR.
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 8'h90;
    bus.cmd_len   = 8'd7;
    bus.cmd_size  = 3'd2;
    bus.arready   = 1'b1;
    bus.out_ready = 1'b1;
    bus.rvalid    = 1'b1;
    bus.rdata     = 32'h5000_0000;
    bus.rresp     = 2'b00;
    bus.rlast     = 1'b0;
    #1;
    check("mid_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
    #1;
    check("mid_addr_arvalid", 32'(bus.arvalid), 32'd1);
    check("mid_addr_no_rready", {30'd0, bus.rready, bus.out_valid}, 32'd0);
    @(posedge aclk); #2;
    check("mid_beat0_valid", 32'(bus.out_valid), 32'd1);
    check("mid_beat0_data", bus.out_data, 32'h5000_0000);
    @(posedge aclk); #1;
    bus.rdata = 32'h5000_0001;
    aresetn   = 1'b0;
    #1;
    @(posedge aclk); #1;
    aresetn    = 1'b1;
    bus.rvalid = 1'b0;
    #1;
    check("mid_rst_quiet", {28'd0, bus.arvalid, bus.rready, bus.busy, bus.done}, 32'd0);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    saw_done = 0;
    repeat (5) begin
      @(posedge aclk); #2;
      if (bus.done) saw_done = 1;
    end
    check("mid_rst_no_done", 32'(saw_done), 32'd0);

    run_vec(vecs[0], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
